pdm_sample_sequencer: RTL

//  Paces signed PCM samples into the 2nd-order delta-sigma PDM modulator. Holds each sample for 2^OSR_LOG2 clocks.

---
 rtl/pdm_seq_pkg.sv | 17 +
 rtl/pdm_seq_fifo.sv | 48 ++++
 rtl/pdm_sample_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pdm_seq_pkg.sv
// Shared types and constants for the PDM sample sequencer.
package pdm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } seq_state_e;

    localparam int unsigned UNDERRUN_CNT_W = 16;

    function automatic int unsigned gain_unity(input int unsigned ramp_log2);
        return 32'd1 << ramp_log2;
    endfunction

endpackage

// File: rtl/pdm_seq_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and single-cycle flush.
module pdm_seq_fifo #(
    parameter int unsigned W    = 16,
    parameter int unsigned LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int unsigned DEPTH = 2 ** LOG2;

    logic [W-1:0] r_mem [DEPTH];
    logic [LOG2:0] r_wr;
    logic [LOG2:0] r_rd;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[LOG2] != r_rd[LOG2]) && (r_wr[LOG2-1:0] == r_rd[LOG2-1:0]);
    assign o_head    = r_mem[r_rd[LOG2-1:0]];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[LOG2-1:0]] <= i_data;
    end

endmodule

// File: rtl/pdm_sample_sequencer.sv
// Paces buffered PCM samples into a delta-sigma modulator with soft-start/stop gain ramp.
// Optional PDM_SEQ_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module pdm_sample_sequencer
    import pdm_seq_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned OSR_LOG2  = 6,
    parameter int unsigned RAMP_LOG2 = 4,
    parameter int unsigned FIFO_LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic [W-1:0] mod_din,
    output logic         mod_tick,
    output logic         running,
    output logic         underrun
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);
    localparam int unsigned GW = RAMP_LOG2 + 1;
    localparam int unsigned PW = W + RAMP_LOG2 + 1;
    localparam logic [GW-1:0] GAIN_UNITY = GW'(gain_unity(RAMP_LOG2));
    localparam logic [GW-1:0] GAIN_ONE   = GW'(1);
    localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;

    seq_state_e            r_state;
    logic [OSR_LOG2-1:0]   r_cnt;
    logic [GW-1:0]         r_gain;
    logic signed [W-1:0]   r_held;
    logic                  w_tick;
    logic                  w_flush;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_underrun;
    logic [W-1:0]          w_head;
    logic signed [PW-1:0]  w_prod;

    pdm_seq_fifo #(.W(W), .LOG2(FIFO_LOG2)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_tick     = (r_state != IDLE) && (r_cnt == CNT_LAST);
    assign w_flush    = w_tick && (r_state == RAMP_DOWN) && !enable && (r_gain <= GAIN_ONE);
    assign w_push     = s_valid && s_ready;
    assign w_pop      = w_tick && !w_empty && !w_flush;
    assign w_underrun = w_tick && w_empty && ((r_state == RAMP_UP) || (r_state == RUN));

    assign s_ready  = !w_full && !w_flush;
    assign mod_tick = w_tick;
    assign running  = (r_state != IDLE);
    assign underrun = w_underrun;

    // Gain is zero-extended so the product stays signed; gain <= unity keeps it in PW bits.
    assign w_prod = $signed({{(RAMP_LOG2 + 1){r_held[W-1]}}, r_held}) * $signed({{W{1'b0}}, r_gain});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gain  <= '0;
            r_held  <= '0;
            mod_din <= '0;
        end else begin
            mod_din <= W'(w_prod >>> RAMP_LOG2);
            r_cnt   <= (r_state == IDLE) ? '0 : r_cnt + 1'b1;

            if (w_flush)    r_held <= '0;
            else if (w_pop) r_held <= $signed(w_head);

            case (r_state)
                IDLE: begin
                    if (enable) r_state <= RAMP_UP;
                end
                RAMP_UP: begin
                    if (!enable) begin
                        r_state <= RAMP_DOWN;
                    end else if (w_tick) begin
                        // Saturate at unity even when re-entered from RAMP_DOWN at full gain.
                        if (r_gain >= GAIN_UNITY - 1'b1) begin
                            r_gain  <= GAIN_UNITY;
                            r_state <= RUN;
                        end else begin
                            r_gain <= r_gain + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!enable) r_state <= RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (enable) begin
                        r_state <= RAMP_UP;
                    end else if (w_tick) begin
                        if (r_gain <= GAIN_ONE) begin
                            r_gain  <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_gain <= r_gain - 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] r_urun_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_urun_cnt <= '0;
        else if (w_underrun && (r_urun_cnt != '1)) r_urun_cnt <= r_urun_cnt + 1'b1;
    end

    assign underrun_cnt = r_urun_cnt;
`endif

endmodule
